// File: rtl/alu_rs_param_pkg.sv
// Shared CPU definitions for the ALU reservation station: default widths,
// the "no producer" tag value and the ALU opcode encodings.
package alu_rs_param_pkg;

  localparam int RS_DEPTH_DEF = 4;
  localparam int TAG_W_DEF    = 4;
  localparam int XLEN_DEF     = 32;
  localparam int OP_W_DEF     = 5;

  // A producer tag of zero means the operand value is already present.
  localparam int TAG_NONE = 0;

  typedef enum logic [OP_W_DEF-1:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_SLT  = 5'd8,
    ALU_SLTU = 5'd9
  } alu_op_e;

endpackage

// File: rtl/alu_rs_param_age_picker.sv
// Oldest-ready selector: grants the ready entry holding the smallest age.
// Ages of valid entries are unique, so at most one grant bit is set.
module rs_age_picker #(
  parameter int DEPTH = 4,
  parameter int AGE_W = 2
) (
  input  logic [DEPTH-1:0]            ready,
  input  logic [DEPTH-1:0][AGE_W-1:0] age,
  output logic [DEPTH-1:0]            grant,
  output logic                        valid
);

  logic [AGE_W-1:0] best;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise synthesis infers a latch.
    grant = '0;
    valid = 1'b0;
    best  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!valid || age[i] < best)) begin
        grant    = '0;
        grant[i] = 1'b1;
        valid    = 1'b1;
        best     = age[i];
      end
    end
  end

endmodule

// File: rtl/alu_rs_param.sv
// ALU reservation station: holds dispatched ALU ops until both operands arrive
// over the CDB, then issues the oldest ready op to the external ALU.
module alu_rs_param
  import alu_rs_param_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int XLEN  = XLEN_DEF,
  parameter int OP_W  = OP_W_DEF
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      flush_in,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [OP_W-1:0]           disp_op,
  input  logic [XLEN-1:0]           disp_vj,
  input  logic [XLEN-1:0]           disp_vk,
  input  logic [TAG_W-1:0]          disp_qj,
  input  logic [TAG_W-1:0]          disp_qk,
  input  logic [TAG_W-1:0]          disp_dest,
  input  logic [XLEN-1:0]           disp_addr,
  input  logic                      cdb_active,
  input  logic [TAG_W-1:0]          cdb_tag,
  input  logic [XLEN-1:0]           cdb_val,
  output logic                      iss_valid,
  output logic [OP_W-1:0]           iss_op,
  output logic [XLEN-1:0]           iss_op1,
  output logic [XLEN-1:0]           iss_op2,
  output logic [XLEN-1:0]           iss_addr,
  output logic [TAG_W-1:0]          iss_dest,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int AGE_W = $clog2(DEPTH);
  localparam int CNT_W = AGE_W + 1;
  localparam logic [TAG_W-1:0] TAG_NIL = TAG_W'(TAG_NONE);

  logic [DEPTH-1:0]            e_valid;
  logic [DEPTH-1:0][AGE_W-1:0] e_age;
  logic [OP_W-1:0]             e_op   [DEPTH];
  logic [XLEN-1:0]             e_vj   [DEPTH];
  logic [XLEN-1:0]             e_vk   [DEPTH];
  logic [TAG_W-1:0]            e_qj   [DEPTH];
  logic [TAG_W-1:0]            e_qk   [DEPTH];
  logic [TAG_W-1:0]            e_dest [DEPTH];
  logic [XLEN-1:0]             e_addr [DEPTH];

  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] grant;
  logic             any_ready;
  logic [AGE_W-1:0] iss_idx;
  logic [AGE_W-1:0] iss_age;
  logic [AGE_W-1:0] free_idx;
  logic             free_found;
  logic             alloc;
  logic             byp_j;
  logic             byp_k;

  // Readiness comes from registered tags only, so a wakeup needs a full cycle
  // before the woken entry can be picked.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      ready[i] = e_valid[i] && (e_qj[i] == TAG_NIL) && (e_qk[i] == TAG_NIL);
  end

  rs_age_picker #(
    .DEPTH (DEPTH),
    .AGE_W (AGE_W)
  ) u_picker (
    .ready (ready),
    .age   (e_age),
    .grant (grant),
    .valid (any_ready)
  );

  always_comb begin
    iss_idx    = '0;
    iss_age    = '0;
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        iss_idx = AGE_W'(i);
        iss_age = e_age[i];
      end
      if (!e_valid[i] && !free_found) begin
        free_idx   = AGE_W'(i);
        free_found = 1'b1;
      end
    end
  end

  assign disp_ready = (count < CNT_W'(DEPTH)) && rdy_in && !flush_in;
  assign alloc      = disp_valid && disp_ready;
  assign byp_j      = cdb_active && (disp_qj != TAG_NIL) && (disp_qj == cdb_tag);
  assign byp_k      = cdb_active && (disp_qk != TAG_NIL) && (disp_qk == cdb_tag);
  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      // NOTE: the entry arrays are reset here because operands must read back
      // as zero after reset; plain storage without that need is left unreset.
      e_valid   <= '0;
      e_age     <= '0;
      count     <= '0;
      iss_valid <= 1'b0;
      iss_op    <= '0;
      iss_op1   <= '0;
      iss_op2   <= '0;
      iss_addr  <= '0;
      iss_dest  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_op[i]   <= '0;
        e_vj[i]   <= '0;
        e_vk[i]   <= '0;
        e_qj[i]   <= '0;
        e_qk[i]   <= '0;
        e_dest[i] <= '0;
        e_addr[i] <= '0;
      end
    end else if (!rdy_in) begin
      iss_valid <= 1'b0;
    end else if (flush_in) begin
      e_valid   <= '0;
      e_age     <= '0;
      count     <= '0;
      iss_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every entry sees the
      // pre-edge state regardless of statement order.
      iss_valid <= any_ready;
      if (any_ready) begin
        iss_op            <= e_op[iss_idx];
        iss_op1           <= e_vj[iss_idx];
        iss_op2           <= e_vk[iss_idx];
        iss_addr          <= e_addr[iss_idx];
        iss_dest          <= e_dest[iss_idx];
        e_valid[iss_idx]  <= 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_active && cdb_tag != TAG_NIL && e_valid[i]) begin
          if (e_qj[i] == cdb_tag) begin
            e_vj[i] <= cdb_val;
            e_qj[i] <= TAG_NIL;
          end
          if (e_qk[i] == cdb_tag) begin
            e_vk[i] <= cdb_val;
            e_qk[i] <= TAG_NIL;
          end
        end
        if (any_ready && e_valid[i] && e_age[i] > iss_age)
          e_age[i] <= e_age[i] - AGE_W'(1);
      end
      // The free slot was invalid before this edge, so it never collides
      // with the entry being issued or woken.
      if (alloc) begin
        e_valid[free_idx] <= 1'b1;
        e_op[free_idx]    <= disp_op;
        e_vj[free_idx]    <= byp_j ? cdb_val : disp_vj;
        e_vk[free_idx]    <= byp_k ? cdb_val : disp_vk;
        e_qj[free_idx]    <= byp_j ? TAG_NIL : disp_qj;
        e_qk[free_idx]    <= byp_k ? TAG_NIL : disp_qk;
        e_dest[free_idx]  <= disp_dest;
        e_addr[free_idx]  <= disp_addr;
        e_age[free_idx]   <= any_ready ? AGE_W'(count - CNT_W'(1)) : AGE_W'(count);
      end
      if (alloc && !any_ready)
        count <= count + CNT_W'(1);
      else if (!alloc && any_ready)
        count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_rs_param.sv
// Self-checking bench for alu_rs_param: an in-order queue model of the station
// compared every cycle, plus directed scenarios with literal expectations.
module tb_alu_rs_param;
  import alu_rs_param_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int XLEN  = 32;
  localparam int OP_W  = 5;

  logic             clk_in = 1'b0;
  logic             rst_in, rdy_in, flush_in;
  logic             disp_valid, disp_ready;
  logic [OP_W-1:0]  disp_op;
  logic [XLEN-1:0]  disp_vj, disp_vk, disp_addr;
  logic [TAG_W-1:0] disp_qj, disp_qk, disp_dest;
  logic             cdb_active;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_val;
  logic             iss_valid;
  logic [OP_W-1:0]  iss_op;
  logic [XLEN-1:0]  iss_op1, iss_op2, iss_addr;
  logic [TAG_W-1:0] iss_dest;
  logic [$clog2(DEPTH):0] count;
  logic             full, empty;

  always #5 clk_in = ~clk_in;

  alu_rs_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .OP_W(OP_W)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .flush_in   (flush_in),
    .disp_valid (disp_valid),
    .disp_ready (disp_ready),
    .disp_op    (disp_op),
    .disp_vj    (disp_vj),
    .disp_vk    (disp_vk),
    .disp_qj    (disp_qj),
    .disp_qk    (disp_qk),
    .disp_dest  (disp_dest),
    .disp_addr  (disp_addr),
    .cdb_active (cdb_active),
    .cdb_tag    (cdb_tag),
    .cdb_val    (cdb_val),
    .iss_valid  (iss_valid),
    .iss_op     (iss_op),
    .iss_op1    (iss_op1),
    .iss_op2    (iss_op2),
    .iss_addr   (iss_addr),
    .iss_dest   (iss_dest),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: entries kept in a queue in dispatch order, so the oldest is first.
  typedef struct {
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  vj, vk, addr;
    logic [TAG_W-1:0] qj, qk, dest;
  } ent_t;

  ent_t             q[$];
  logic             m_iss_valid;
  logic [OP_W-1:0]  m_op;
  logic [XLEN-1:0]  m_op1, m_op2, m_addr;
  logic [TAG_W-1:0] m_dest;

  always @(posedge clk_in or posedge rst_in) begin : model
    int   sel;
    bit   can_alloc;
    bit   bj, bk;
    ent_t n;
    if (rst_in) begin
      q.delete();
      m_iss_valid = 1'b0;
      m_op = '0; m_op1 = '0; m_op2 = '0; m_addr = '0; m_dest = '0;
    end else if (!rdy_in) begin
      m_iss_valid = 1'b0;
    end else if (flush_in) begin
      q.delete();
      m_iss_valid = 1'b0;
    end else begin
      can_alloc = (q.size() < DEPTH);
      sel = -1;
      foreach (q[i]) if (sel < 0 && q[i].qj == 0 && q[i].qk == 0) sel = i;
      m_iss_valid = (sel >= 0);
      if (sel >= 0) begin
        m_op = q[sel].op; m_op1 = q[sel].vj; m_op2 = q[sel].vk;
        m_addr = q[sel].addr; m_dest = q[sel].dest;
        q.delete(sel);
      end
      if (cdb_active && cdb_tag != 0) begin
        foreach (q[i]) begin
          if (q[i].qj == cdb_tag) begin q[i].vj = cdb_val; q[i].qj = 0; end
          if (q[i].qk == cdb_tag) begin q[i].vk = cdb_val; q[i].qk = 0; end
        end
      end
      if (disp_valid && can_alloc) begin
        bj = cdb_active && disp_qj != 0 && disp_qj == cdb_tag;
        bk = cdb_active && disp_qk != 0 && disp_qk == cdb_tag;
        n.op = disp_op; n.addr = disp_addr; n.dest = disp_dest;
        n.vj = bj ? cdb_val : disp_vj;
        n.vk = bk ? cdb_val : disp_vk;
        n.qj = bj ? '0 : disp_qj;
        n.qk = bk ? '0 : disp_qk;
        q.push_back(n);
      end
    end
  end

  always @(negedge clk_in) begin
    if (!rst_in && run_cmp) begin
      check("cmp_iss_valid", iss_valid, m_iss_valid);
      check("cmp_iss_op", iss_op, m_op);
      check("cmp_iss_op1", iss_op1, m_op1);
      check("cmp_iss_op2", iss_op2, m_op2);
      check("cmp_iss_addr", iss_addr, m_addr);
      check("cmp_iss_dest", iss_dest, m_dest);
      check("cmp_count", count, q.size());
      check("cmp_full", full, q.size() == DEPTH);
      check("cmp_empty", empty, q.size() == 0);
      check("cmp_disp_ready", disp_ready, (q.size() < DEPTH) && rdy_in && !flush_in);
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_disp(input logic [OP_W-1:0] op, input logic [XLEN-1:0] vj,
                            input logic [XLEN-1:0] vk, input logic [TAG_W-1:0] qj,
                            input logic [TAG_W-1:0] qk, input logic [TAG_W-1:0] dest,
                            input logic [XLEN-1:0] addr);
    disp_valid = 1'b1;
    disp_op = op; disp_vj = vj; disp_vk = vk;
    disp_qj = qj; disp_qk = qk; disp_dest = dest; disp_addr = addr;
  endtask

  task automatic set_cdb(input logic act, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val);
    cdb_active = act; cdb_tag = tag; cdb_val = val;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; disp_valid = 1'b0;
    disp_op = '0; disp_vj = '0; disp_vk = '0; disp_qj = '0; disp_qk = '0;
    disp_dest = '0; disp_addr = '0;
    set_cdb(1'b0, '0, '0);
    #2;
    check("rst_iss_valid", iss_valid, 1'b0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_iss_op1", iss_op1, 0);
    check("rst_iss_dest", iss_dest, 0);
    step(); step();
    rst_in = 1'b0;
    run_cmp = 1'b1;

    // Single ready op issues on the edge after dispatch.
    drive_disp(ALU_ADD, 32'd5, 32'd7, 4'd0, 4'd0, 4'd3, 32'h100);
    step();
    disp_valid = 1'b0;
    check("add_count_held", count, 1);
    check("add_no_early_issue", iss_valid, 1'b0);
    step();
    check("add_iss_valid", iss_valid, 1'b1);
    check("add_op1", iss_op1, 32'd5);
    check("add_op2", iss_op2, 32'd7);
    check("add_dest", iss_dest, 4'd3);
    check("add_count_zero", count, 0);

    // Fill with waiters on tag 2, wake all at once, drain in dispatch order.
    for (int k = 0; k < DEPTH; k++) begin
      drive_disp(ALU_SUB, 32'h0, 32'(k + 1), 4'd2, 4'd0, 4'(k + 1), 32'h200 + 32'(4 * k));
      step();
    end
    disp_valid = 1'b0;
    check("fill_full", full, 1'b1);
    check("fill_disp_ready", disp_ready, 1'b0);
    set_cdb(1'b1, 4'd2, 32'h10);
    step();
    set_cdb(1'b0, '0, '0);
    check("wake_no_same_cycle_issue", iss_valid, 1'b0);
    drive_disp(ALU_ADD, 32'h1, 32'h1, 4'd0, 4'd0, 4'd9, 32'h2F0);
    for (int k = 0; k < DEPTH; k++) begin
      step();
      if (k == 0) disp_valid = 1'b0;
      check("drain_valid", iss_valid, 1'b1);
      check("drain_dest", iss_dest, 4'(k + 1));
      check("drain_op1", iss_op1, 32'h10);
    end
    step();
    check("drain_done", iss_valid, 1'b0);
    check("drain_count", count, 0);

    // Dispatch-time bypass from the CDB.
    drive_disp(ALU_XOR, 32'h0, 32'h3, 4'd6, 4'd0, 4'd4, 32'h300);
    set_cdb(1'b1, 4'd6, 32'hAB);
    step();
    disp_valid = 1'b0;
    set_cdb(1'b0, '0, '0);
    step();
    check("byp_valid", iss_valid, 1'b1);
    check("byp_op1", iss_op1, 32'hAB);

    // Younger ready entry overtakes an older waiting one.
    drive_disp(ALU_OR, 32'h11, 32'h0, 4'd0, 4'd4, 4'd5, 32'h400);
    step();
    drive_disp(ALU_AND, 32'h22, 32'h33, 4'd0, 4'd0, 4'd6, 32'h404);
    step();
    disp_valid = 1'b0;
    set_cdb(1'b1, 4'd4, 32'h44);
    step();
    set_cdb(1'b0, '0, '0);
    check("ooo_first_dest", iss_dest, 4'd6);
    check("ooo_first_op1", iss_op1, 32'h22);
    step();
    check("ooo_second_dest", iss_dest, 4'd5);
    check("ooo_second_op2", iss_op2, 32'h44);
    step();

    // Flush a full station while a dispatch is offered.
    for (int k = 0; k < DEPTH; k++) begin
      drive_disp(ALU_SLT, 32'(k), 32'(k), 4'd9, 4'd0, 4'(k + 1), 32'h600 + 32'(k));
      step();
    end
    flush_in = 1'b1;
    drive_disp(ALU_ADD, 32'h7, 32'h7, 4'd0, 4'd0, 4'd7, 32'h700);
    #1;
    check("flush_disp_ready", disp_ready, 1'b0);
    step();
    flush_in = 1'b0;
    disp_valid = 1'b0;
    check("flush_count", count, 0);
    check("flush_empty", empty, 1'b1);
    set_cdb(1'b1, 4'd9, 32'h99);
    repeat (2) begin
      step();
      set_cdb(1'b0, '0, '0);
      check("flush_no_issue", iss_valid, 1'b0);
    end

    // rdy_in low freezes state and drops a CDB broadcast.
    drive_disp(ALU_ADD, 32'h1, 32'h1, 4'd8, 4'd0, 4'd7, 32'h500);
    step();
    drive_disp(ALU_SUB, 32'h55, 32'h5, 4'd0, 4'd0, 4'd8, 32'h504);
    step();
    rdy_in = 1'b0;
    set_cdb(1'b1, 4'd8, 32'h88);
    repeat (3) begin
      step();
      check("stall_no_issue", iss_valid, 1'b0);
      check("stall_count", count, 2);
    end
    rdy_in = 1'b1;
    disp_valid = 1'b0;
    set_cdb(1'b0, '0, '0);
    step();
    check("resume_issue", iss_valid, 1'b1);
    check("resume_dest", iss_dest, 4'd8);
    check("resume_count", count, 1);
    step();
    check("lost_cdb_no_issue", iss_valid, 1'b0);
    set_cdb(1'b1, 4'd8, 32'h99);
    step();
    set_cdb(1'b0, '0, '0);
    step();
    check("late_wake_op1", iss_op1, 32'h99);

    // Asynchronous reset in the middle of an issue cycle.
    #2;
    rst_in = 1'b1;
    #1;
    check("async_rst_iss_valid", iss_valid, 1'b0);
    check("async_rst_count", count, 0);
    check("async_rst_iss_dest", iss_dest, 0);
    step(); step();
    rst_in = 1'b0;
    step();
    check("post_rst_idle", iss_valid, 1'b0);
    drive_disp(ALU_ADD, 32'h2, 32'h3, 4'd0, 4'd0, 4'd1, 32'h800);
    step();
    disp_valid = 1'b0;
    step();
    check("post_rst_op1", iss_op1, 32'h2);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_rs_param.md
ALU_RS_PARAM -- requirements
Module: alu_rs_param

Interface
REQ-001 Parameter DEPTH, default 4, number of entries (power of two, 2..16).
REQ-002 Parameter TAG_W, default 4, width of rename tags; tag value 0 means None (operand ready).
REQ-003 Parameter XLEN, default 32, operand/result width.
REQ-004 Parameter OP_W, default 5, ALU opcode width.
REQ-005 clk_in  input  1  clock; all state updates on rising edge.
REQ-006 rst_in  input  1  reset, asynchronous, active-high.
REQ-007 rdy_in  input  1  global enable; low freezes all state.
REQ-008 flush_in  input  1  mispredict flush; clears all entries.
REQ-009 disp_valid  input  1  dispatch request.
REQ-010 disp_ready  output  1  entry available; high iff count < DEPTH, rdy_in high, flush_in low.
REQ-011 disp_op  input  OP_W  ALU opcode.
REQ-012 disp_vj, disp_vk  input  XLEN each  operand values (vk already imm-muxed by dispatcher).
REQ-013 disp_qj, disp_qk  input  TAG_W each  producer tags, 0 = ready.
REQ-014 disp_dest  input  TAG_W  result tag (ROB index) of this instruction, nonzero.
REQ-015 disp_addr  input  XLEN  instruction PC.
REQ-016 cdb_active, cdb_tag, cdb_val  input  1/TAG_W/XLEN  result broadcast.
REQ-017 iss_valid  output  1  registered issue to ALU.
REQ-018 iss_op, iss_op1, iss_op2, iss_addr, iss_dest  output  OP_W/XLEN/XLEN/XLEN/TAG_W  issued payload.
REQ-019 count  output  $clog2(DEPTH)+1  occupied entries; full, empty  output  1 each.

Function
REQ-020 Allocation occurs when disp_valid && disp_ready; new entry written into lowest-index free slot at the clock edge.
REQ-021 Dispatch bypass: if cdb_active and cdb_tag equals nonzero disp_qj (disp_qk) in the allocation cycle, entry stores cdb_val with qj (qk) = 0.
REQ-022 Wakeup: each cycle with cdb_active, every valid entry with qj (qk) == cdb_tag takes vj (vk) = cdb_val, qj (qk) = 0; tag 0 never matches.
REQ-023 Entry ready iff valid, qj == 0, qk == 0; readiness judged on registered state (no same-cycle wakeup-to-issue).
REQ-024 Issue selects the oldest ready entry; each entry holds age in 0..count-1, 0 = oldest.
REQ-025 On issue of entry of age a, entries with age > a decrement; new allocation takes age = count minus 1 if an issue occurs same cycle, else count.
REQ-026 Issue latency: selected entry appears on iss_* one cycle later with iss_valid high for exactly one cycle; entry freed on that same edge.
REQ-027 iss_valid low and iss_* hold last values when no entry ready.
REQ-028 Allocation and issue in the same cycle both take effect; count unchanged.
REQ-029 disp_ready depends only on registered count (full entries block dispatch even if an issue frees one that cycle).
REQ-030 flush_in (with rdy_in high) clears all valid bits, ages, count, and iss_valid next edge; overrides allocation, wakeup, issue.
REQ-031 rdy_in low: no allocation, wakeup, issue or flush; iss_valid forced low on the next edge; stored state retained.
REQ-032 CDB broadcast during rdy_in low is lost; producers must hold until rdy_in high.

Reset
REQ-033 rst_in high immediately clears all valid bits, ages, operands, count = 0, empty = 1, full = 0, iss_valid = 0, iss_* = 0.
REQ-034 Reset mid-operation discards all entries; no issue occurs on the edge reset deasserts.

Structure
REQ-035 TAG_NONE, ALU opcode encodings and default widths live in the shared cpu package/macros file.
REQ-036 Oldest-ready selection is a sub-module rs_age_picker (inputs ready vector, age vector; outputs one-hot grant, valid).
REQ-037 ALU is not instantiated inside; iss_* drives the external alu.

Verification
REQ-038 Dispatch op ADD, vj=5, vk=7, qj=qk=0 -> iss_valid next cycle with op1=5, op2=7, dest=3; count returns to 0.
REQ-039 Fill DEPTH=4 entries with qj=2 -> full=1, disp_ready=0; cdb tag 2 val 0x10 -> all four issue in dispatch order over 4 consecutive cycles, op1=0x10.
REQ-040 Dispatch qj=6 while cdb_active tag 6 val 0xAB same cycle -> entry issues next cycle with op1=0xAB.
REQ-041 Entry A (older, qk=4) and B (younger, ready); cdb tag 4 -> B issues first, A next cycle.
REQ-042 Full RS with flush_in and disp_valid same cycle -> count=0, empty=1, no iss_valid afterwards.
REQ-043 rdy_in low for 3 cycles with ready entry -> no issue, state held; issue one cycle after rdy_in returns high; async rst_in mid-cycle clears iss_valid immediately.
